// File: rtl/traffic_phase_sequencer.sv
// Intersection phase controller: walks the light phases, reloads the shared
// countdown timer on each phase entry and advances on accepted expiry pulses.
module traffic_phase_sequencer #(
  parameter int ARM_MASK = 2
) (
  input  logic       clk,
  input  logic       Reset_Sync,
  input  logic       Sensor,
  input  logic       Walk_Request,
  input  logic       expired,
  output logic       start_timer,
  output logic [1:0] Interval_Select,
  output logic [2:0] Main_Lights,
  output logic [2:0] Side_Lights,
  output logic       Walk_Lamp,
  output logic [2:0] Phase
);

  localparam logic [2:0] S_MG1  = 3'd0;
  localparam logic [2:0] S_MG2  = 3'd1;
  localparam logic [2:0] S_MY   = 3'd2;
  localparam logic [2:0] S_SG1  = 3'd3;
  localparam logic [2:0] S_SG2  = 3'd4;
  localparam logic [2:0] S_SY   = 3'd5;
  localparam logic [2:0] S_WALK = 3'd6;

  localparam logic [1:0] I_BASE = 2'b00;
  localparam logic [1:0] I_EXT  = 2'b01;
  localparam logic [1:0] I_YEL  = 2'b10;

  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_RED = 3'b100;

  localparam int MW = (ARM_MASK < 1) ? 1 : $clog2(ARM_MASK + 1);

  logic [2:0]    state, nxt;
  logic          walk_pending;
  logic          init_start;
  logic [MW-1:0] mask_cnt;
  logic          accept, enter, load;
  logic [1:0]    isel_nxt;
  logic [2:0]    main_nxt, side_nxt;

  // Expiry is blind while the timer is still loading after a start pulse.
  assign accept = expired && !init_start && (mask_cnt == '0);
  assign enter  = (nxt != state);
  assign load   = enter || init_start;

  always_comb begin
    nxt = state;
    if (state == 3'd7) begin
      nxt = S_MG1;
    end else if (accept) begin
      case (state)
        S_MG1:   nxt = S_MG2;
        S_MG2:   nxt = S_MY;
        S_MY:    nxt = S_SG1;
        S_SG1:   nxt = Sensor ? S_SG2 : S_SY;
        S_SG2:   nxt = S_SY;
        S_SY:    nxt = walk_pending ? S_WALK : S_MG1;
        default: nxt = S_MG1;
      endcase
    end
  end

  always_comb begin
    isel_nxt = I_BASE;
    main_nxt = L_RED;
    side_nxt = L_RED;
    case (nxt)
      S_MG1:  main_nxt = L_GRN;
      S_MG2:  begin main_nxt = L_GRN; isel_nxt = Sensor ? I_EXT : I_BASE; end
      S_MY:   begin main_nxt = L_YEL; isel_nxt = I_YEL; end
      S_SG1:  side_nxt = L_GRN;
      S_SG2:  begin side_nxt = L_GRN; isel_nxt = I_EXT; end
      S_SY:   begin side_nxt = L_YEL; isel_nxt = I_YEL; end
      S_WALK: isel_nxt = I_EXT;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset_Sync) begin
      state           <= S_MG1;
      walk_pending    <= 1'b0;
      init_start      <= 1'b1;
      mask_cnt        <= '0;
      start_timer     <= 1'b0;
      Interval_Select <= I_BASE;
      Main_Lights     <= L_GRN;
      Side_Lights     <= L_RED;
      Walk_Lamp       <= 1'b0;
      Phase           <= S_MG1;
    end else begin
      state       <= nxt;
      Phase       <= nxt;
      init_start  <= 1'b0;
      start_timer <= load;
      Main_Lights <= main_nxt;
      Side_Lights <= side_nxt;
      Walk_Lamp   <= (nxt == S_WALK);
      if (enter)
        Interval_Select <= isel_nxt;
      if (load)
        mask_cnt <= MW'(ARM_MASK);
      else if (mask_cnt != '0)
        mask_cnt <= mask_cnt - 1'b1;
      // Entering WALK consumes the request, including one arriving this cycle.
      if (enter && nxt == S_WALK)
        walk_pending <= 1'b0;
      else if (Walk_Request && state != S_WALK)
        walk_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: timer environment model, phase-level
// reference model checked every cycle, plus directed sequence checks.
module tb_traffic_phase_sequencer;
  localparam int ARM_MASK = 2;
  localparam int TICK     = 4;

  logic clk = 1'b0;
  logic Reset_Sync = 1'b0, Sensor = 1'b0, Walk_Request = 1'b0, expired = 1'b0;
  logic       start_timer, Walk_Lamp;
  logic [1:0] Interval_Select;
  logic [2:0] Main_Lights, Side_Lights, Phase;

  traffic_phase_sequencer #(.ARM_MASK(ARM_MASK)) dut (
    .clk(clk), .Reset_Sync(Reset_Sync), .Sensor(Sensor),
    .Walk_Request(Walk_Request), .expired(expired),
    .start_timer(start_timer), .Interval_Select(Interval_Select),
    .Main_Lights(Main_Lights), .Side_Lights(Side_Lights),
    .Walk_Lamp(Walk_Lamp), .Phase(Phase)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;

  // phase tables: 0 MG1,1 MG2,2 MY,3 SG1,4 SG2,5 SY,6 WALK
  int main_tab [7] = '{1, 1, 2, 4, 4, 4, 4};
  int side_tab [7] = '{4, 4, 4, 1, 1, 2, 4};
  int isel_tab [7] = '{0, 0, 2, 0, 1, 2, 1};
  int succ_tab [7] = '{1, 2, 3, 5, 5, 0, 0};

  int         m_phase = 0, m_since = 0;
  bit         m_pend = 0, m_init = 0, m_start = 0, m_valid = 0;
  logic [1:0] m_isel = 2'b00;

  int  tcnt = 0, cyc = 0, force_left = 0;
  bit  tload = 0, rec = 0, noise = 0, arm_force = 0;
  bit  req_at_walk = 0, req_in_walk = 0;
  int  seq[$];
  int  seqi[$];

  function automatic int dur(logic [1:0] s);
    case (s)
      2'b01:   return 3;
      2'b10:   return 2;
      default: return 6;
    endcase
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  task automatic model_step(input bit rst, input bit sens, input bit wreq, input bit e);
    bit acc;
    int nxt;
    if (!rst) begin
      m_phase = 0; m_pend = 0; m_init = 1; m_start = 0;
      m_isel = 2'b00; m_since = 0; m_valid = 1;
      return;
    end
    acc = e && !m_init && (m_since >= ARM_MASK);
    nxt = m_phase;
    if (acc) begin
      nxt = succ_tab[m_phase];
      if (m_phase == 3 && sens) nxt = 4;
      if (m_phase == 5 && m_pend) nxt = 6;
    end
    if (acc && nxt == 6) m_pend = 0;
    else if (wreq && m_phase != 6) m_pend = 1;
    if (acc) m_isel = (nxt == 1) ? {1'b0, sens} : 2'(isel_tab[nxt]);
    m_start = acc || m_init;
    m_init  = 0;
    m_since = m_start ? 0 : (m_since < 100 ? m_since + 1 : m_since);
    m_phase = nxt;
  endtask

  task automatic do_cycle(input bit rst, input bit sens, input bit wreq);
    bit e;
    @(negedge clk);
    cyc++;
    if (m_valid) begin
      checks++;
      if (Phase !== 3'(m_phase) || Main_Lights !== 3'(main_tab[m_phase]) ||
          Side_Lights !== 3'(side_tab[m_phase]) || Walk_Lamp !== (m_phase == 6) ||
          start_timer !== m_start || Interval_Select !== m_isel)
        $display("FAIL cycle%0d actual ph=%0d main=%b side=%b walk=%b st=%b isel=%b required ph=%0d main=%0d side=%0d st=%0d isel=%b",
                 cyc, Phase, Main_Lights, Side_Lights, Walk_Lamp, start_timer, Interval_Select,
                 m_phase, main_tab[m_phase], side_tab[m_phase], m_start, m_isel);
      else passes++;
    end
    if (rec && start_timer) begin
      seq.push_back(int'(Phase));
      seqi.push_back(int'(Interval_Select));
    end
    // timer environment: samples Interval_Select one cycle after the start pulse
    e = 0;
    if (tload) begin tcnt = dur(Interval_Select); tload = 0; end
    if (start_timer) begin tload = 1; tcnt = 0; end
    if (cyc % TICK == 0 && tcnt > 0) begin
      tcnt--;
      if (tcnt == 0) e = 1;
    end
    if (arm_force && start_timer) begin force_left = 3; arm_force = 0; end
    if (force_left > 0) begin e = 1; force_left--; end
    if (noise && $urandom_range(19) == 0) e = 1;
    if (req_at_walk && e && Phase == 3'd5) begin wreq = 1; req_at_walk = 0; end
    if (req_in_walk && Phase == 3'd6) begin wreq = 1; req_in_walk = 0; end
    if (!rst) begin tcnt = 0; tload = 0; end
    Reset_Sync = rst; Sensor = sens; Walk_Request = wreq; expired = e;
    model_step(rst, sens, wreq, e);
  endtask

  task automatic run_seq(input string name, input bit sens, input bit walk_first,
                         input int exp_q[$]);
    bit lamp_done = 0;
    int n = 0;
    repeat (2) do_cycle(0, 0, 0);
    seq.delete(); seqi.delete(); rec = 1;
    do_cycle(1, sens, walk_first);
    while (seq.size() < exp_q.size() && n < 3000) begin
      do_cycle(1, sens, 0);
      n++;
      if (!lamp_done && Phase == 3'd6) begin
        lamp_done = 1;
        check({name, "_walk_lamps"}, {Walk_Lamp, Main_Lights, Side_Lights}, 10'b1_100_100 & 7'h7f);
      end
    end
    rec = 0;
    check({name, "_len"}, seq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seq.size(); i++)
      check($sformatf("%s_ph%0d", name, i), seq[i], exp_q[i]);
  endtask

  initial begin
    int qa[$], qb[$], qc[$];
    qa = '{0, 1, 2, 3, 5, 0};
    qb = '{0, 1, 2, 3, 4, 5, 0};
    qc = '{0, 1, 2, 3, 5, 6, 0, 1, 2, 3, 5, 0};

    // reset values, post-release start, expiry masking
    repeat (3) do_cycle(0, 0, 0);
    do_cycle(1, 0, 0);
    check("rst_phase", Phase, 0);
    check("rst_main", Main_Lights, 3'b001);
    check("rst_side", Side_Lights, 3'b100);
    check("rst_start", start_timer, 0);
    check("rst_isel", Interval_Select, 0);
    check("rst_walk", Walk_Lamp, 0);
    arm_force = 1;
    do_cycle(1, 0, 0);
    check("post_rst_start", start_timer, 1);
    repeat (2) do_cycle(1, 0, 0);
    check("mask_hold", Phase, 0);
    do_cycle(1, 0, 0);
    check("mask_release_ph", Phase, 1);
    check("mask_release_st", start_timer, 1);

    run_seq("base", 0, 0, qa);
    run_seq("sensor", 1, 0, qb);
    if (seqi.size() >= 5) begin
      check("sensor_mg2_isel", seqi[1], 1);
      check("sensor_sg2_isel", seqi[4], 1);
    end else check("sensor_isel_len", seqi.size(), 5);
    run_seq("walk", 0, 1, qc);
    req_at_walk = 1; req_in_walk = 1;
    run_seq("walk_dup", 0, 1, qc);
    check("walk_dup_armed", {req_at_walk, req_in_walk}, 0);

    // reset in mid-SG2 with a pending walk
    repeat (2) do_cycle(0, 0, 0);
    do_cycle(1, 1, 1);
    for (int n = 0; n < 3000 && Phase != 3'd4; n++) do_cycle(1, 1, 0);
    check("reach_sg2", Phase, 4);
    repeat (2) do_cycle(1, 1, 0);
    do_cycle(0, 1, 0);
    do_cycle(1, 0, 0);
    check("midrst_phase", Phase, 0);
    check("midrst_main", Main_Lights, 3'b001);
    check("midrst_start", start_timer, 0);
    seq.delete(); seqi.delete(); rec = 1;
    do_cycle(1, 0, 0);
    check("midrst_restart", start_timer, 1);
    for (int n = 0; n < 3000 && seq.size() < qa.size(); n++) do_cycle(1, 0, 0);
    rec = 0;
    check("midrst_len", seq.size(), qa.size());
    for (int i = 0; i < qa.size() && i < seq.size(); i++)
      check($sformatf("midrst_ph%0d", i), seq[i], qa[i]);

    // randomized traffic with stray expiry pulses and occasional resets
    noise = 1;
    begin
      bit s = 0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(9) == 0) s = ~s;
        do_cycle(($urandom_range(399) != 0) && n > 1, s, $urandom_range(11) == 0);
      end
    end
    noise = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Top-level phase controller for the intersection. It walks the light phases in order, tells the time-parameter block which interval to apply, starts the shared countdown timer at each phase entry, and advances only when the timer reports expiry. It also latches pedestrian walk requests and applies the traffic-sensor extension rules. It sits between the 1 Hz divider/timer pair and the lamp drivers.

Parameters:
ARM_MASK, 2, number of cycles after a start_timer pulse during which expired is ignored (covers the timer's one-cycle load latency)

Ports:
clk  input  1  system clock, single domain
Reset_Sync  input  1  synchronous, active-low reset (sampled on posedge clk)
Sensor  input  1  side-street vehicle present, already synchronised
Walk_Request  input  1  pedestrian request, one-cycle pulse, already debounced
expired  input  1  timer expiry pulse, coincident with a oneHz_enable cycle
start_timer  output  1  one-cycle pulse: timer reload
Interval_Select  output  2  00=tBASE, 01=tEXT, 10=tYEL, 11 unused
Main_Lights  output  3  {red,yellow,green}
Side_Lights  output  3  {red,yellow,green}
Walk_Lamp  output  1  pedestrian walk lamp
Phase  output  3  current state encoding, for debug

Behaviour:
- All outputs are registered.
- States and their encodings: MG1=0, MG2=1, MY=2, SG1=3, SG2=4, SY=5, WALK=6. Encoding 7 is illegal and recovers to MG1 on the next clock.
- Reset (Reset_Sync=0 at posedge):
  - state=MG1, walk_pending=0, mask counter=0.
  - Outputs: start_timer=0, Interval_Select=00, Main_Lights=001, Side_Lights=100, Walk_Lamp=0, Phase=0.
  - First cycle with Reset_Sync=1: start_timer=1 (timer started for MG1).
- Interval by state:
  - MG1=tBASE.
  - MG2=tEXT if Sensor=1 at MG1 expiry, else tBASE.
  - MY=tYEL.
  - SG1=tBASE.
  - SG2=tEXT.
  - SY=tYEL.
  - WALK=tEXT.
- Transitions (taken only on an accepted expired):
  - MG1->MG2
  - MG2->MY
  - MY->SG1
  - SG1->SG2 if Sensor=1 that cycle, else SG1->SY
  - SG2->SY
  - SY->WALK if walk_pending=1, else SY->MG1
  - WALK->MG1
- Phase entry timing:
  - On the clock edge that changes state, the new state, lamps, Interval_Select and start_timer=1 all appear together.
  - start_timer is high exactly one cycle per phase entry, and at no other time except the post-reset start.
  - Interval_Select is held constant for the whole phase; the timer samples it one cycle after start_timer.
- Expiry masking:
  - expired is ignored in the start_timer cycle and for the following ARM_MASK-1 cycles.
  - A masked pulse is dropped, not deferred.
- Lamps:
  - Main_Lights: 001 in MG1/MG2, 010 in MY, 100 otherwise.
  - Side_Lights: 001 in SG1/SG2, 010 in SY, 100 otherwise.
  - Walk_Lamp=1 only in WALK; both streets are red in WALK.
- Walk latch:
  - A Walk_Request pulse sets walk_pending in any state except WALK.
  - walk_pending clears on entry to WALK.
  - A request arriving in the same cycle as the transition into WALK is absorbed; no second WALK follows.
  - A request arriving during WALK is ignored.
- Sensor is sampled only in the expiry cycle; glitches at other times have no effect.
- Reset asserted mid-phase: the next edge forces the reset values and discards walk_pending. Lamps never show green on both streets.

Test Plan:
- Reset then release, timer model with tBASE=6, tEXT=3, tYEL=2, Sensor=0, no walk -> start_timer pulses at entry of MG1, MG2, MY, SG1, SY, MG1. Phase sequence 0,1,2,3,5,0. Phase durations in 1 Hz ticks: 6,6,2,6,2.
- Sensor=1 held throughout -> MG2 Interval_Select=01 (3 ticks). SG2 visited (Phase=4, 3 ticks). Full cycle = 6+3+2+6+3+2 = 22 ticks.
- Walk_Request pulse during MG1 -> after SY: Phase=6, Walk_Lamp=1, Main_Lights=Side_Lights=100 for 3 ticks, then MG1. Next cycle has no WALK.
- Walk_Request coincident with the SY->WALK edge, plus a second pulse during WALK -> exactly one WALK; the following SY goes to MG1.
- expired forced high in the start_timer cycle and the cycle after -> no state change. expired at start+2 -> transition.
- Reset_Sync=0 for one cycle in mid-SG2 with walk_pending=1 -> next cycle Phase=0, Main_Lights=001, walk_pending=0. start_timer=1 on the first cycle after release.
